// File: rtl/scan_seq_pkg.sv
// Shared types for the scan chain sequencer: FSM state encoding and counter sizing.
package scan_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    FINISH
  } seq_state_e;

  // Bit-counter width for a chain of n flops; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_seq_shreg.sv
// Parallel-load shift register: MSB-first serialiser while loading the chain, SCAN_OUT deserialiser while unloading.
// One shift per strobe; par_nxt_o is the word as it will look after a shift_out this cycle.
module scan_seq_shreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_in,
  input  logic             shift_out,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             scan_in,
  output logic             ser_o,
  output logic [WIDTH-1:0] par_nxt_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_dat;
    end else if (shift_in) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end else if (shift_out) begin
      data_d = {data_q[WIDTH-2:0], scan_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign ser_o     = data_q[WIDTH-1];
  assign par_nxt_o = {data_q[WIDTH-2:0], scan_in};

endmodule

// File: rtl/scan_chain_seq.sv
// Scan chain sequencer: serial load, optional capture, serial unload into RDATA; DONE 2N+1 (2N+2 with capture) cycles after START is driven.
// No backpressure: START is only honoured in IDLE, ABORT cancels any running sequence on the next edge.
module scan_chain_seq
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  input  logic                 START,
  input  logic                 CAPTURE_EN,
  input  logic                 ABORT,
  input  logic                 FUNC_DE,
  input  logic [CHAIN_LEN-1:0] WDATA,
  input  logic                 SCAN_OUT,
  output logic                 SCE_O,
  output logic                 DE_O,
  output logic                 SCD_O,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RDATA
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cap_en_q, cap_en_d;
  logic                 sce_q, sce_d;
  logic                 de_q, de_d;
  logic                 scd_q, scd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;

  logic                 sh_load;
  logic                 sh_in;
  logic                 sh_out;
  logic                 sh_ser;
  logic [CHAIN_LEN-1:0] sh_par_nxt;

  // The MSB leaves through scd_q on the START edge, so the register holds the rest pre-aligned.
  scan_seq_shreg #(
    .WIDTH(CHAIN_LEN)
  ) u_shreg (
    .clk      (CLK),
    .rst_n    (RESET_B),
    .load     (sh_load),
    .shift_in (sh_in),
    .shift_out(sh_out),
    .load_dat ({WDATA[CHAIN_LEN-2:0], 1'b0}),
    .scan_in  (SCAN_OUT),
    .ser_o    (sh_ser),
    .par_nxt_o(sh_par_nxt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_en_d = cap_en_q;
    sce_d    = 1'b0;
    de_d     = 1'b0;
    scd_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    sh_load  = 1'b0;
    sh_in    = 1'b0;
    sh_out   = 1'b0;

    case (state_q)
      IDLE: begin
        de_d = FUNC_DE;
        if (START) begin
          state_d  = SHIFT_IN;
          cnt_d    = '0;
          cap_en_d = CAPTURE_EN;
          sh_load  = 1'b1;
          sce_d    = 1'b1;
          de_d     = 1'b0;
          scd_d    = WDATA[CHAIN_LEN-1];
          busy_d   = 1'b1;
        end
      end
      SHIFT_IN: begin
        sh_in  = 1'b1;
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (cap_en_q) begin
            state_d = CAPTURE;
            de_d    = 1'b1;
          end else begin
            state_d = SHIFT_OUT;
            sce_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          sce_d = 1'b1;
          scd_d = sh_ser;
        end
      end
      CAPTURE: begin
        state_d = SHIFT_OUT;
        cnt_d   = '0;
        sce_d   = 1'b1;
        busy_d  = 1'b1;
      end
      SHIFT_OUT: begin
        sh_out = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FINISH;
          cnt_d   = '0;
          done_d  = 1'b1;
          de_d    = FUNC_DE;
          rdata_d = sh_par_nxt;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          sce_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        de_d    = FUNC_DE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every transition; a partially unloaded word never reaches RDATA.
    if (ABORT && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      sce_d   = 1'b0;
      scd_d   = 1'b0;
      de_d    = FUNC_DE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rdata_d = rdata_q;
      sh_load = 1'b0;
      sh_in   = 1'b0;
      sh_out  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_en_q <= 1'b0;
      sce_q    <= 1'b0;
      de_q     <= 1'b0;
      scd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_en_q <= cap_en_d;
      sce_q    <= sce_d;
      de_q     <= de_d;
      scd_q    <= scd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign SCE_O = sce_q;
  assign DE_O  = de_q;
  assign SCD_O = scd_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_scan_chain_seq.sv
// Bench for scan_chain_seq with an 8-flop behavioural scan-DE chain and a cycle-count reference model.
module tb_scan_chain_seq;

  localparam int N = 8;

  logic         CLK;
  logic         RESET_B;
  logic         START;
  logic         CAPTURE_EN;
  logic         ABORT;
  logic         FUNC_DE;
  logic [N-1:0] WDATA;
  logic         SCAN_OUT;
  logic         SCE_O;
  logic         DE_O;
  logic         SCD_O;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] RDATA;

  logic [N-1:0] chain = '0;
  logic [N-1:0] func_d = '0;

  int n_checks = 0;
  int n_errors = 0;

  scan_chain_seq #(.CHAIN_LEN(N)) dut (
    .CLK       (CLK),
    .RESET_B   (RESET_B),
    .START     (START),
    .CAPTURE_EN(CAPTURE_EN),
    .ABORT     (ABORT),
    .FUNC_DE   (FUNC_DE),
    .WDATA     (WDATA),
    .SCAN_OUT  (SCAN_OUT),
    .SCE_O     (SCE_O),
    .DE_O      (DE_O),
    .SCD_O     (SCD_O),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RDATA     (RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural chain: flop 0 takes SCD, flop i takes flop i-1; DE loads the functional word.
  always @(posedge CLK) begin
    if (SCE_O) chain <= {chain[N-2:0], SCD_O};
    else if (DE_O) chain <= func_d;
  end
  assign SCAN_OUT = chain[N-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is a fixed timeline of cycles counted from acceptance.
  bit           m_act = 1'b0;
  int           m_e = 0;
  logic         m_cap = 1'b0;
  logic [N-1:0] m_w = '0;
  logic [N-1:0] m_func = '0;
  logic [N-1:0] m_rdata = '0;
  logic         e_sce = 1'b0, e_de = 1'b0, e_scd = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      m_act = 1'b0; m_e = 0; m_rdata = '0;
      e_sce = 1'b0; e_de = 1'b0; e_scd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      if (m_act && ABORT) begin
        m_act = 1'b0;
      end else if (m_act) begin
        if (m_cap && m_e == N) m_func = func_d;
        m_e++;
        if (m_e > 2 * N + int'(m_cap)) m_act = 1'b0;
      end else if (START) begin
        m_act = 1'b1; m_e = 0; m_w = WDATA; m_cap = CAPTURE_EN;
      end
      e_sce = 1'b0; e_de = 1'b0; e_scd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (!m_act) begin
        e_de = FUNC_DE;
      end else if (m_e < N) begin
        e_sce = 1'b1; e_scd = m_w[N-1-m_e]; e_busy = 1'b1;
      end else if (m_cap && m_e == N) begin
        e_de = 1'b1; e_busy = 1'b1;
      end else if (m_e < 2 * N + int'(m_cap)) begin
        e_sce = 1'b1; e_busy = 1'b1;
      end else begin
        e_done = 1'b1; e_de = FUNC_DE;
        m_rdata = m_cap ? m_func : m_w;
      end
    end
  end

  always @(negedge CLK) begin
    check("cyc_sce",   32'(SCE_O), 32'(e_sce));
    check("cyc_de",    32'(DE_O),  32'(e_de));
    check("cyc_scd",   32'(SCD_O), 32'(e_scd));
    check("cyc_busy",  32'(BUSY),  32'(e_busy));
    check("cyc_done",  32'(DONE),  32'(e_done));
    check("cyc_rdata", 32'(RDATA), 32'(m_rdata));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch a sequence right after an edge and watch until DONE (bounded).
  task automatic run_seq(input logic [N-1:0] w, input logic cap, input logic [N-1:0] fd,
                         output int lat, output int sce_run, output int cap_cyc);
    int run;
    func_d = fd; WDATA = w; CAPTURE_EN = cap; START = 1'b1;
    lat = -1; sce_run = 0; cap_cyc = 0; run = 0;
    for (int j = 1; j <= 40 && lat < 0; j++) begin
      tick();
      START = 1'b0;
      if (SCE_O) begin
        run++;
        if (run > sce_run) sce_run = run;
      end else begin
        run = 0;
      end
      if (!SCE_O && DE_O && BUSY) cap_cyc++;
      if (DONE) lat = j;
    end
  endtask

  initial begin
    int lat, sce_run, cap_cyc, ndone;
    bit seen_done, fin_pulsed;
    RESET_B = 1'b0; START = 1'b0; CAPTURE_EN = 1'b0; ABORT = 1'b0; FUNC_DE = 1'b0; WDATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_sce",   32'(SCE_O), 32'd0);
    check("reset_de",    32'(DE_O),  32'd0);
    check("reset_busy",  32'(BUSY),  32'd0);
    check("reset_done",  32'(DONE),  32'd0);
    check("reset_rdata", 32'(RDATA), 32'd0);
    RESET_B = 1'b1;
    tick();

    run_seq(8'hA5, 1'b0, 8'h00, lat, sce_run, cap_cyc);
    check("pass_latency", 32'(lat), 32'd17);
    check("pass_sce_run", 32'(sce_run), 32'd16);
    check("pass_no_capture", 32'(cap_cyc), 32'd0);
    check("pass_rdata", 32'(RDATA), 32'h A5);
    tick(); tick();

    run_seq(8'hFF, 1'b1, 8'h3C, lat, sce_run, cap_cyc);
    check("cap_latency", 32'(lat), 32'd18);
    check("cap_sce_run", 32'(sce_run), 32'd8);
    check("cap_one_cycle", 32'(cap_cyc), 32'd1);
    check("cap_rdata", 32'(RDATA), 32'h3C);
    tick();

    func_d = 8'h55; FUNC_DE = 1'b1;
    tick();
    check("fwd_de_rise", 32'(DE_O), 32'd1);
    check("fwd_sce_low", 32'(SCE_O), 32'd0);
    check("fwd_chain_held", 32'(chain), 32'h00);
    FUNC_DE = 1'b0;
    tick();
    check("fwd_de_fall", 32'(DE_O), 32'd0);
    check("fwd_chain_loaded", 32'(chain), 32'h55);
    tick();

    WDATA = 8'h0F; CAPTURE_EN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (N + 4) tick();
    check("abort_in_shift_out", 32'({SCE_O, BUSY}), 32'b11);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abort_sce", 32'(SCE_O), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    seen_done = 1'b0;
    repeat (30) begin
      tick();
      if (DONE) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    check("abort_rdata_kept", 32'(RDATA), 32'h3C);

    WDATA = 8'h5A; CAPTURE_EN = 1'b0; START = 1'b1;
    ndone = 0; fin_pulsed = 1'b0;
    for (int j = 1; j <= 45; j++) begin
      tick();
      START = 1'b0;
      if (j == 3) begin
        START = 1'b1; WDATA = 8'h00;
      end
      if (DONE) begin
        ndone++;
        if (!fin_pulsed) begin
          START = 1'b1; CAPTURE_EN = 1'b1; fin_pulsed = 1'b1;
        end
      end
    end
    START = 1'b0; CAPTURE_EN = 1'b0;
    check("ign_done_seen", 32'(fin_pulsed), 32'd1);
    check("ign_one_done", 32'(ndone), 32'd1);
    check("ign_busy_low", 32'(BUSY), 32'd0);
    check("ign_rdata", 32'(RDATA), 32'h5A);

    WDATA = 8'hC3; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    check("rst_pre_sce", 32'(SCE_O), 32'd1);
    #3 RESET_B = 1'b0;
    #1;
    check("rst_sce",   32'(SCE_O), 32'd0);
    check("rst_de",    32'(DE_O),  32'd0);
    check("rst_scd",   32'(SCD_O), 32'd0);
    check("rst_busy",  32'(BUSY),  32'd0);
    check("rst_done",  32'(DONE),  32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    @(negedge CLK);
    #2 RESET_B = 1'b1;
    tick();
    run_seq(8'hC3, 1'b0, 8'h00, lat, sce_run, cap_cyc);
    check("rst_rerun_latency", 32'(lat), 32'd17);
    check("rst_rerun_rdata", 32'(RDATA), 32'hC3);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
